mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that responds on the CPU data-memory interface, alongside the memory controller. It decodes CPU stores and loads to its register window and queues bytes in a small TX FIFO. Bytes are serialised as 8N1 on a single output pin. Read data is zero outside its window so the top level can OR it with the memory controller's read data.

Parameters:
ADDR_W, `MEMORY_DEPTH, address bus width
DATA_W, `MEMORY_WIDTH, data bus width (>= 16)
BASE_ADDR, 'h100, word-aligned base of the 3-register window
FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2
BAUD_DIV_RST, 434, reset clocks-per-bit (115200 baud at 50 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
memory_write_address  in  ADDR_W  CPU store address
memory_write_data  in  DATA_W  CPU store data
memory_write_enable  in  1  CPU store strobe, one cycle per store
memory_read_address  in  ADDR_W  CPU load address
memory_read_data  out  DATA_W  load data; 0 when address is outside the window
uart_txd  out  1  serial output, idle high

Behaviour:
- Register map, exact address compare:
  - BASE+0 TXDATA: write pushes data[7:0]; reads return 0.
  - BASE+4 STATUS: read-only except bit3. bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), [15:8] FIFO count. Writing 1 to bit3 clears overflow.
  - BASE+8 BAUD_DIV: R/W, bits [15:0]. Value 0 is treated as 1.
- All other addresses are ignored for writes and read as 0.
- Reads are combinational from registered state, valid the same cycle, and have no side effects.
- Push behaviour:
  - A push when count == FIFO_DEPTH is dropped and sets overflow.
  - Full is taken from the registered count, so a push while full is dropped even if a pop occurs in the same cycle.
  - A push to an empty FIFO is visible in STATUS the next cycle.
- Serialiser FSM: IDLE, START, DATA, STOP.
  - IDLE: txd = 1. If the FIFO is not empty: pop into the shift register, latch BAUD_DIV into the bit timer, go to START.
  - START: txd = 0 for div cycles, then DATA.
  - DATA: LSB first. Each bit lasts div cycles. bit_cnt runs 0..7, then STOP.
  - STOP: txd = 1 for div cycles.
  - End of STOP with FIFO non-empty: pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Character length is exactly 10*div cycles.
- Latency: a store to TXDATA while IDLE and empty drives the start bit 2 cycles after the store cycle (1 cycle FIFO write, 1 cycle pop/load).
- BAUD_DIV writes take effect only at the next character start; the character in flight keeps its latched div.
- uart_txd is registered (glitch-free).
- Reset values:
  - uart_txd = 1, FSM = IDLE.
  - FIFO empty, count 0, overflow 0, BAUD_DIV = BAUD_DIV_RST.
  - memory_read_data is 0 unless the read address is in the window.
- Reset mid-character: txd returns high asynchronously and queued bytes are discarded.
- A store to STATUS with bit3 = 0 has no effect. A simultaneous overflow event and clear leaves overflow = 1 (set wins).

Decomposition:
- Package mmio_uart_pkg:
  - Register offsets TXDATA_OFS = 0, STATUS_OFS = 4, BAUD_OFS = 8.
  - STATUS bit positions.
  - tx_state_t enum {IDLE, START, DATA, STOP}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Ports push, pop, din, dout, full, empty, count.
  - Pointers one bit wider than log2(DEPTH) for the full/empty distinction.
  - Wrap-around via natural pointer overflow.
- Top module contains only the address decode, CSRs and serialiser FSM.

Test Plan:
- Reset, then read BASE+8 and BASE+4 → 434 and 0x0000_0002 (empty); uart_txd = 1 throughout.
- Write BAUD_DIV = 4, store 0x55 to TXDATA at cycle T → txd low for T+2..T+5, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high. busy drops at T+42.
- Write BAUD_DIV = 2, store 0x01, 0x80, 0xFF back-to-back → three 20-cycle characters, no idle gap between stop and start, then empty = 1.
- Issue 10 stores with FIFO_DEPTH = 8 in consecutive cycles while IDLE → 1 popped immediately, 8 queued, 1 dropped. STATUS overflow = 1, count = 8. Write 0x8 to STATUS → overflow = 0.
- Mid-character (during DATA bit 3), assert rst_n = 0 for 1 cycle → txd = 1 immediately, STATUS = 0x0000_0002, BAUD_DIV = 434. No further serial activity.
- Read addresses BASE+12 and 0x0 → memory_read_data = 0. Store to BASE+12 → no STATUS or BAUD change.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_pkg
// Description : Shared register offsets, STATUS bit positions and serialiser
//               state type for the memory-mapped UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_pkg;

    // Byte offsets of the three registers from the window base
    localparam int TXDATA_OFS = 0;
    localparam int STATUS_OFS = 4;
    localparam int BAUD_OFS   = 8;

    // STATUS register bit positions
    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_MSB = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // A programmed divider of zero behaves as one clock per bit
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with extra-bit pointers so full and empty
//               are distinguishable; pointers wrap by natural overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (count_o == (AW+1)'(DEPTH));
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign dout_o    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; full/empty come from registered pointers only
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers, cleared on reset so queued data is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUD_DIV
//               register window, TX FIFO and bit serialiser. Read data is
//               zero outside the window so it can be ORed onto the bus.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef MEMORY_DEPTH
`define MEMORY_DEPTH 32
`endif
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int                ADDR_W       = `MEMORY_DEPTH,
    parameter int                DATA_W       = `MEMORY_WIDTH,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 'h100,
    parameter int                FIFO_DEPTH   = 8,
    parameter int                BAUD_DIV_RST = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] memory_write_address,
    input  logic [DATA_W-1:0] memory_write_data,
    input  logic              memory_write_enable,
    input  logic [ADDR_W-1:0] memory_read_address,
    output logic [DATA_W-1:0] memory_read_data,
    output logic              uart_txd
);

    localparam int                CW            = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] c_ADDR_TXDATA = BASE_ADDR + ADDR_W'(TXDATA_OFS);
    localparam logic [ADDR_W-1:0] c_ADDR_STATUS = BASE_ADDR + ADDR_W'(STATUS_OFS);
    localparam logic [ADDR_W-1:0] c_ADDR_BAUD   = BASE_ADDR + ADDR_W'(BAUD_OFS);

    // CSR state
    logic [15:0] baud_q, baud_d;
    logic        ovf_q, ovf_d;

    // Serialiser state
    tx_state_t   state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;

    // FIFO interface
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_dout;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;

    logic              w_ovf_clr;
    logic              w_bit_end;
    logic [DATA_W-1:0] w_status;
    logic              w_unused_wdata;

    assign w_unused_wdata = ^memory_write_data[DATA_W-1:16];

    assign w_push    = memory_write_enable && (memory_write_address == c_ADDR_TXDATA);
    assign w_ovf_clr = memory_write_enable && (memory_write_address == c_ADDR_STATUS)
                       && memory_write_data[STAT_OVF];
    assign w_bit_end = (timer_q == 16'd0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (memory_write_data[7:0]),
        .dout_o  (w_dout),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // CSR next state: a dropped push sets overflow and wins over a clear
    always_comb begin
        baud_d = baud_q;
        ovf_d  = ovf_q;
        if (memory_write_enable && (memory_write_address == c_ADDR_BAUD))
            baud_d = memory_write_data[15:0];
        if (w_ovf_clr)
            ovf_d = 1'b0;
        if (w_push && w_full)
            ovf_d = 1'b1;
    end

    // CSR registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q <= 16'(BAUD_DIV_RST);
            ovf_q  <= 1'b0;
        end else begin
            baud_q <= baud_d;
            ovf_q  <= ovf_d;
        end
    end

    // Serialiser next state; every bit period lasts div_q cycles
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        w_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_dout;
                    div_d   = eff_div(baud_q);
                    timer_d = eff_div(baud_q) - 16'd1;
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    timer_d   = div_q - 16'd1;
                    bit_cnt_d = 3'd0;
                    txd_d     = shift_q[0];
                    state_d   = DATA;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    timer_d = div_q - 16'd1;
                    if (bit_cnt_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        // Back-to-back character: straight into the start bit
                        w_pop   = 1'b1;
                        shift_d = w_dout;
                        div_d   = eff_div(baud_q);
                        timer_d = eff_div(baud_q) - 16'd1;
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Serialiser registers; the line returns high immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= 16'd0;
            div_q     <= 16'd1;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    assign uart_txd = txd_q;

    // STATUS image assembled from registered state
    always_comb begin
        w_status                             = '0;
        w_status[STAT_FULL]                  = w_full;
        w_status[STAT_EMPTY]                 = w_empty;
        w_status[STAT_BUSY]                  = (state_q != IDLE);
        w_status[STAT_OVF]                   = ovf_q;
        w_status[STAT_CNT_MSB:STAT_CNT_LSB]  = 8'(w_count);
    end

    // Side-effect-free read mux; zero outside the register window
    always_comb begin
        memory_read_data = '0;
        if (memory_read_address == c_ADDR_STATUS)
            memory_read_data = w_status;
        else if (memory_read_address == c_ADDR_BAUD)
            memory_read_data = DATA_W'(baud_q);
    end

endmodule
`default_nettype wire
